// File: rtl/vx_ti_mem_rsp.sv
// Responder end of a ti-unit cache bus lane: local word SRAM, fixed-latency read pipe and an
// in-order response FIFO, with credit-based request gating so no response is ever dropped.
module vx_ti_mem_rsp #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int TAG_W     = 8,
  parameter int DEPTH     = 256,
  parameter int LATENCY   = 2,
  parameter int RSP_DEPTH = 4,
  parameter bit WRITE_ACK = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_rw,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_data,
  input  logic [DATA_W/8-1:0] req_byteen,
  input  logic [TAG_W-1:0]    req_tag,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_data,
  output logic [TAG_W-1:0]    rsp_tag,
  output logic                busy
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BYTES = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  idx;
  logic              ready_en;
  logic [CNT_W-1:0]  outstanding;
  logic              accept;
  logic              responding;
  logic              push;
  logic              pop;

  logic [LATENCY-1:0] pipe_v;
  logic [DATA_W-1:0]  pipe_d [LATENCY];
  logic [TAG_W-1:0]   pipe_t [LATENCY];

  logic [DATA_W-1:0] fifo_d [RSP_DEPTH];
  logic [TAG_W-1:0]  fifo_t [RSP_DEPTH];
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;

  // Upper address bits are deliberately ignored; the index wraps modulo DEPTH.
  assign idx = req_addr[IDX_W-1:0];
  generate
    if (ADDR_W > IDX_W) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^req_addr[ADDR_W-1:IDX_W];
    end
  endgenerate

  // A credit is reserved at accept, so FIFO space exists whenever a pipe entry lands.
  assign req_ready  = ready_en && (outstanding < CNT_W'(RSP_DEPTH));
  assign accept     = req_valid && req_ready;
  assign responding = !req_rw || WRITE_ACK;
  assign push       = pipe_v[LATENCY-1];
  assign rsp_valid  = (wr_ptr != rd_ptr);
  assign pop        = rsp_valid && rsp_ready;
  assign rsp_data   = fifo_d[rd_ptr[PTR_W-1:0]];
  assign rsp_tag    = fifo_t[rd_ptr[PTR_W-1:0]];
  assign busy       = (outstanding != '0);

  // NOTE: storage arrays carry no reset; only valids, pointers and counters are cleared.
  always_ff @(posedge clk) begin
    if (accept && req_rw) begin
      for (int b = 0; b < BYTES; b++) begin
        if (req_byteen[b]) mem[idx][b*8 +: 8] <= req_data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_en <= 1'b0;
      pipe_v   <= '0;
    end else begin
      ready_en  <= 1'b1;
      pipe_v[0] <= accept && responding;
      for (int i = 1; i < LATENCY; i++) pipe_v[i] <= pipe_v[i-1];
    end
  end

  always_ff @(posedge clk) begin
    pipe_d[0] <= req_rw ? '0 : mem[idx];
    pipe_t[0] <= req_tag;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_d[i] <= pipe_d[i-1];
      pipe_t[i] <= pipe_t[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_d[wr_ptr[PTR_W-1:0]] <= pipe_d[LATENCY-1];
      fifo_t[wr_ptr[PTR_W-1:0]] <= pipe_t[LATENCY-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({accept && responding, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end
endmodule

// File: tb/tb_vx_ti_mem_rsp.sv
// Directed bench for vx_ti_mem_rsp: latency, byte enables, credit back-pressure, streaming,
// index wrap and reset with traffic in flight.
module tb_vx_ti_mem_rsp;
  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_rw;
  logic [31:0] req_addr, req_data;
  logic [3:0]  req_byteen;
  logic [7:0]  req_tag;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [7:0]  rsp_tag;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [31:0] rx_d [$];
  logic [7:0]  rx_t [$];
  int          rx_c [$];

  vx_ti_mem_rsp dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw), .req_addr(req_addr),
    .req_data(req_data), .req_byteen(req_byteen), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Inputs change just after posedge, so at negedge a valid&ready pair means a pop at the next edge.
  always @(negedge clk) begin
    if (reset && rsp_valid && rsp_ready) begin
      rx_d.push_back(rsp_data);
      rx_t.push_back(rsp_tag);
      rx_c.push_back(cyc);
    end
  end

  task automatic clear_rx();
    rx_d.delete(); rx_t.delete(); rx_c.delete();
  endtask

  task automatic do_req(input logic rw, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] be, input logic [7:0] tag);
    bit ok = 0;
    req_valid = 1'b1; req_rw = rw; req_addr = addr; req_data = data;
    req_byteen = be; req_tag = tag;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL req_accept_timeout addr=%0h got no accept, required accept within 50 cycles", addr);
    end
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (!busy && !rsp_valid) ok = 1;
    end
    @(posedge clk); #1;
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL idle_timeout busy=%0b rsp_valid=%0b, required both 0 within 100 cycles", busy, rsp_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; req_data = '0;
    req_byteen = '0; req_tag = '0; rsp_ready = 1'b1;
    #12;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got %0b required 0", rsp_valid); end
    n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL reset_busy got %0b required 0", busy); end
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_req_ready got %0b required 0", req_ready); end
    #10 reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_req_ready got %0b required 1", req_ready); end
  endtask

  task automatic test_write_read();
    int lat = 1;
    bit seen = 0;
    clear_rx();
    do_req(1'b1, 32'd5, 32'hDEADBEEF, 4'hF, 8'h00);
    do_req(1'b0, 32'd5, 32'h0, 4'h0, 8'h11);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
      else begin @(posedge clk); #1; lat++; end
    end
    n_cmp++; if (lat !== LAT + 1) begin n_bad++; $display("FAIL read_latency got %0d required %0d", lat, LAT + 1); end
    n_cmp++; if (rsp_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL read_data got %08h required deadbeef", rsp_data); end
    n_cmp++; if (rsp_tag !== 8'h11) begin n_bad++; $display("FAIL read_tag got %02h required 11", rsp_tag); end
    @(posedge clk); #1;
    wait_idle();
    n_cmp++; if (rx_d.size() !== 1) begin n_bad++; $display("FAIL write_no_ack rsp_count got %0d required 1", rx_d.size()); end
  endtask

  task automatic test_byteen();
    clear_rx();
    do_req(1'b1, 32'd7, 32'h12345678, 4'hF, 8'h00);
    do_req(1'b1, 32'd7, 32'h000000AA, 4'h1, 8'h00);
    do_req(1'b0, 32'd7, 32'h0, 4'h0, 8'h22);
    wait_idle();
    n_cmp++;
    if (rx_d.size() !== 1 || rx_d[0] !== 32'h123456AA || rx_t[0] !== 8'h22) begin
      n_bad++;
      $display("FAIL byteen_merge count=%0d data=%08h tag=%02h required 1/123456aa/22",
               rx_d.size(), rx_d.size() > 0 ? rx_d[0] : 32'hx, rx_t.size() > 0 ? rx_t[0] : 8'hx);
    end
  endtask

  task automatic test_backpressure();
    int n_acc = 0;
    for (int i = 0; i < 6; i++) do_req(1'b1, 32'd20 + i, 32'hA0 + i, 4'hF, 8'h00);
    clear_rx();
    rsp_ready = 1'b0; req_rw = 1'b0;
    for (int c = 0; c < 12; c++) begin
      req_valid = 1'b1; req_addr = 32'd20 + n_acc; req_tag = 8'h30 + 8'(n_acc);
      @(negedge clk);
      if (req_ready) n_acc++;
      @(posedge clk); #1;
    end
    n_cmp++; if (n_acc !== 4) begin n_bad++; $display("FAIL stall_accepts got %0d required 4", n_acc); end
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL stall_req_ready got %0b required 0", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_tag !== 8'h30 || rsp_data !== 32'hA0) begin
      n_bad++; $display("FAIL stall_head valid=%0b tag=%02h data=%08h required 1/30/000000a0", rsp_valid, rsp_tag, rsp_data);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    for (int c = 0; c < 40 && n_acc < 6; c++) begin
      req_valid = 1'b1; req_addr = 32'd20 + n_acc; req_tag = 8'h30 + 8'(n_acc);
      @(negedge clk);
      if (req_ready) n_acc++;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    wait_idle();
    n_cmp++; if (rx_d.size() !== 6) begin n_bad++; $display("FAIL stall_rsp_count got %0d required 6", rx_d.size()); end
    for (int i = 0; i < 6 && i < rx_d.size(); i++) begin
      n_cmp++;
      if (rx_t[i] !== 8'h30 + 8'(i) || rx_d[i] !== 32'hA0 + i) begin
        n_bad++; $display("FAIL stall_order[%0d] tag=%02h data=%08h required %02h/%08h",
                          i, rx_t[i], rx_d[i], 8'h30 + 8'(i), 32'hA0 + i);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n_acc = 0;
    for (int i = 0; i < 16; i++) do_req(1'b1, 32'd64 + i, i * 32'h01010101, 4'hF, 8'h00);
    clear_rx();
    req_rw = 1'b0;
    for (int i = 0; i < 16; i++) begin
      req_valid = 1'b1; req_addr = 32'd64 + i; req_tag = 8'(i);
      @(negedge clk);
      if (req_ready) n_acc++;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    wait_idle();
    n_cmp++; if (n_acc !== 16) begin n_bad++; $display("FAIL b2b_accepts got %0d required 16 in 16 cycles", n_acc); end
    n_cmp++; if (rx_d.size() !== 16) begin n_bad++; $display("FAIL b2b_rsp_count got %0d required 16", rx_d.size()); end
    else begin
      n_cmp++;
      if (rx_c[15] - rx_c[0] !== 15) begin n_bad++; $display("FAIL b2b_rsp_span got %0d cycles required 15", rx_c[15] - rx_c[0]); end
      for (int i = 0; i < 16; i++) begin
        n_cmp++;
        if (rx_t[i] !== 8'(i) || rx_d[i] !== i * 32'h01010101) begin
          n_bad++; $display("FAIL b2b[%0d] tag=%02h data=%08h required %02h/%08h",
                            i, rx_t[i], rx_d[i], 8'(i), i * 32'h01010101);
        end
      end
    end
  endtask

  task automatic test_addr_wrap();
    clear_rx();
    do_req(1'b1, 32'd3, 32'hCAFEF00D, 4'hF, 8'h00);
    do_req(1'b0, 32'(DEPTH + 3), 32'h0, 4'h0, 8'h44);
    wait_idle();
    n_cmp++;
    if (rx_d.size() !== 1 || rx_d[0] !== 32'hCAFEF00D || rx_t[0] !== 8'h44) begin
      n_bad++;
      $display("FAIL addr_wrap count=%0d data=%08h tag=%02h required 1/cafef00d/44",
               rx_d.size(), rx_d.size() > 0 ? rx_d[0] : 32'hx, rx_t.size() > 0 ? rx_t[0] : 8'hx);
    end
  endtask

  task automatic test_reset_midflight();
    rsp_ready = 1'b0; req_rw = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_addr = 32'd64 + i; req_tag = 8'h50 + 8'(i);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL midflight_busy got %0b required 1", busy); end
    reset = 1'b0;
    #1;
    n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL midflight_reset valid=%0b busy=%0b required 0/0", rsp_valid, busy);
    end
    clear_rx();
    rsp_ready = 1'b1;
    @(posedge clk); @(posedge clk); #3;
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin @(posedge clk); #1; end
    n_cmp++; if (rx_d.size() !== 0) begin n_bad++; $display("FAIL midflight_stale got %0d responses required 0", rx_d.size()); end
    n_cmp++; if (req_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL midflight_recover ready=%0b busy=%0b required 1/0", req_ready, busy);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byteen();
    test_backpressure();
    test_back_to_back();
    test_addr_wrap();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
